// File: rtl/imageproc_cmd_arb.sv
// Round-robin arbiter sharing the image processor command port among NREQ requesters.
// One command in flight at a time; the next grant waits for ack and for the processor to go idle.
module imageproc_cmd_arb #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [4*NREQ-1:0]       req_cmd,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         req_err,
  output logic [3:0]              cmd,
  output logic [7:0]              cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ack,
  input  logic                    busy,
  input  logic                    refresh,
  input  logic                    error,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    timeout_seen
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          found;
  logic [IW-1:0] win;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (int'(ptr) + k) % int'(NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    cnt_inc     = (cnt == CW'(ACK_TIMEOUT)) ? cnt : cnt + 1'b1;
    timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == CW'(ACK_TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      ptr          <= '0;
      cnt          <= '0;
      cmd          <= '0;
      cmd_data     <= '0;
      cmd_valid    <= 1'b0;
      req_ack      <= '0;
      req_err      <= '0;
      owner        <= '0;
      timeout_seen <= 1'b0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      unique case (state)
        StIdle: begin
          if (!busy && !refresh && found) begin
            cmd       <= req_cmd[4*win +: 4];
            cmd_data  <= req_data[8*win +: 8];
            owner     <= win;
            ptr       <= (int'(win) == int'(NREQ) - 1) ? '0 : win + 1'b1;
            cnt       <= '0;
            cmd_valid <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          if (error) begin
            req_err[owner] <= 1'b1;
            cmd_valid      <= 1'b0;
            state          <= StIdle;
          end else if (cmd_ack) begin
            req_ack[owner] <= 1'b1;
            cmd_valid      <= 1'b0;
            state          <= StWait;
          end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              req_err[owner] <= 1'b1;
              timeout_seen   <= 1'b1;
              cmd_valid      <= 1'b0;
              state          <= StIdle;
            end
          end
        end
        StWait: begin
          if (error) begin
            req_err[owner] <= 1'b1;
            state          <= StIdle;
          end else if (!busy) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imageproc_cmd_arb.sv
// Directed bench for imageproc_cmd_arb: inputs driven and outputs sampled on the falling edge.
module tb_imageproc_cmd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_cmd;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  req_err;
  logic [3:0]  cmd;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ack;
  logic        busy;
  logic        refresh;
  logic        error;
  logic [1:0]  owner;
  logic        timeout_seen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imageproc_cmd_arb #(
    .NREQ        (4),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .cmd          (cmd),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ack      (cmd_ack),
    .busy         (busy),
    .refresh      (refresh),
    .error        (error),
    .owner        (owner),
    .timeout_seen (timeout_seen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_cmd   = '0;
    req_data  = '0;
    cmd_ack   = 1'b0;
    busy      = 1'b0;
    refresh   = 1'b0;
    error     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int n;
    logic pending;

    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_owner", owner, 0);
    check("rst_ack", req_ack, 0);
    check("rst_err", req_err, 0);
    check("rst_timeout_seen", timeout_seen, 0);

    // Single request from requester 2, acked on its third issue cycle, busy for 5 cycles
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_cmd   = 16'h0500;
    req_data  = 32'h00A3_0000;
    tick();
    check("single_cv1", cmd_valid, 1);
    check("single_cmd", cmd, 4'h5);
    check("single_data", cmd_data, 8'hA3);
    check("single_owner", owner, 2);
    tick();
    check("single_cv2", cmd_valid, 1);
    tick();
    check("single_cv3", cmd_valid, 1);
    cmd_ack = 1'b1;
    busy    = 1'b1;
    tick();
    check("single_cv_drop", cmd_valid, 0);
    check("single_ack", req_ack, 4'b0100);
    check("single_no_err", req_err, 0);
    cmd_ack   = 1'b0;
    req_valid = 4'b0010;
    req_cmd   = 16'h0070;
    req_data  = 32'h0000_5500;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("busy_hold_cv", cmd_valid, 0);
      check("busy_hold_ack", req_ack, 0);
    end
    busy = 1'b0;
    tick();
    check("busy_release_cv", cmd_valid, 0);
    tick();
    check("next_grant_cv", cmd_valid, 1);
    check("next_grant_owner", owner, 1);
    check("next_grant_cmd", cmd, 4'h7);
    cmd_ack = 1'b1;
    tick();
    check("next_grant_ack", req_ack, 4'b0010);
    do_reset();

    // Round-robin with every requester valid and immediate acks
    req_valid = 4'b1111;
    req_cmd   = 16'h4321;
    req_data  = 32'h4030_2010;
    cmd_ack   = 1'b1;
    g         = 0;
    pending   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pending) begin
        check("rr_ack", req_ack, 4'b0001 << ((g - 1) % 4));
        pending = 1'b0;
      end
      if (cmd_valid) begin
        check("rr_owner", owner, g % 4);
        check("rr_cmd", cmd, (g % 4) + 1);
        check("rr_data", cmd_data, ((g % 4) + 1) * 16);
        g++;
        pending = 1'b1;
      end
    end
    check("rr_grant_count", g, 5);
    do_reset();

    // Refresh blocks a grant; a grant follows one cycle after refresh drops
    refresh   = 1'b1;
    req_valid = 4'b0010;
    req_cmd   = 16'h0090;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("refresh_block", cmd_valid, 0);
    end
    refresh = 1'b0;
    tick();
    check("refresh_grant_cv", cmd_valid, 1);
    check("refresh_grant_owner", owner, 1);
    check("refresh_grant_cmd", cmd, 4'h9);
    cmd_ack = 1'b1;
    tick();
    check("refresh_ack", req_ack, 4'b0010);
    cmd_ack   = 1'b0;
    req_valid = 4'b0000;
    tick();
    // Busy in IDLE also blocks; ptr is now 2 so requester 0 wins after wrapping
    busy      = 1'b1;
    req_valid = 4'b0001;
    req_cmd   = 16'h0093;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_block", cmd_valid, 0);
    end
    busy = 1'b0;
    tick();
    check("busy_grant_cv", cmd_valid, 1);
    check("busy_grant_owner", owner, 0);
    check("busy_grant_cmd", cmd, 4'h3);
    cmd_ack = 1'b1;
    tick();
    check("wait_ack", req_ack, 4'b0001);
    cmd_ack   = 1'b0;
    req_valid = 4'b0000;
    busy      = 1'b1;
    error     = 1'b1;
    tick();
    check("wait_err", req_err, 4'b0001);
    check("wait_err_no_ack", req_ack, 0);
    do_reset();

    // Error beats a same-cycle ack during requester 3's issue
    req_valid = 4'b1000;
    req_cmd   = 16'hC000;
    tick();
    check("err_cv", cmd_valid, 1);
    check("err_owner", owner, 3);
    cmd_ack = 1'b1;
    error   = 1'b1;
    tick();
    check("err_pulse", req_err, 4'b1000);
    check("err_no_ack", req_ack, 0);
    check("err_cv_drop", cmd_valid, 0);
    cmd_ack   = 1'b0;
    error     = 1'b0;
    req_valid = 4'b0000;
    tick();
    check("err_pulse_end", req_err, 0);
    do_reset();

    // Ack timeout on requester 0, then requester 1 is granted
    req_valid = 4'b0011;
    n = 0;
    tick();
    while (cmd_valid && n < 40) begin
      n++;
      tick();
    end
    check("to_len", n, 16);
    check("to_err", req_err, 4'b0001);
    check("to_seen", timeout_seen, 1);
    req_valid = 4'b0010;
    tick();
    check("to_next_cv", cmd_valid, 1);
    check("to_next_owner", owner, 1);
    check("to_sticky", timeout_seen, 1);

    // Reset in the middle of an issue
    rst = 1'b1;
    tick();
    check("mid_rst_cv", cmd_valid, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_data", cmd_data, 0);
    check("mid_rst_ack", req_ack, 0);
    check("mid_rst_err", req_err, 0);
    check("mid_rst_seen", timeout_seen, 0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    tick();
    check("post_rst_owner", owner, 1);
    check("post_rst_cv", cmd_valid, 1);
    check("post_rst_err", req_err, 0);
    check("post_rst_ack", req_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
